// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: FSM states,
// the bubble PC marker and the register-index width.
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam logic [31:0] BUBBLE_PC = 32'hFFFF_FFFF;
  localparam int          REG_W     = 4;

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Word-wide data-memory port between the memory-access stage and data memory.
// req rises with addr/we/wdata and holds them stable until the cycle ready is
// high; that cycle completes the access and req drops for at least one cycle.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register: always loads, resets to a bubble.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             regwrite_i,
    input  logic [REG_W-1:0] dest_i,
    input  logic [31:0]      data_i,
    input  logic [31:0]      pc_i,
    output logic             regwrite_o,
    output logic [REG_W-1:0] dest_o,
    output logic [31:0]      data_o,
    output logic [31:0]      pc_o
);

    logic             regwrite_q;
    logic [REG_W-1:0] dest_q;
    logic [31:0]      data_q;
    logic [31:0]      pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
            pc_q       <= BUBBLE_PC;
        end else begin
            regwrite_q <= regwrite_i;
            dest_q     <= dest_i;
            data_q     <= data_i;
            pc_q       <= pc_i;
        end
    end

    assign regwrite_o = regwrite_q;
    assign dest_o     = dest_q;
    assign data_o     = data_q;
    assign pc_o       = pc_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores on the data-memory port, stalls the
// pipeline while an access is outstanding and feeds the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_memread,
    input  logic                 ex_memwrite,
    input  logic                 ex_wbdata,
    input  logic                 ex_regwrite,
    input  logic [31:0]          ex_alu_result,
    input  logic [31:0]          ex_busb,
    input  logic [REG_W-1:0]     ex_dest,
    input  logic [31:0]          ex_pc,
    output logic                 mem_stall,
    mem_access_stage_if.master   dmem,
    output logic                 wb_regwrite,
    output logic [REG_W-1:0]     wb_dest,
    output logic [31:0]          wb_data,
    output logic [31:0]          wb_pc,
    output logic                 misalign_err,
    output logic                 bus_err,
    output mem_state_e           dbg_state
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q, we_q, wbdata_q, regwrite_q;
    logic [31:0]      addr_q, wdata_q, pc_q;
    logic [REG_W-1:0] dest_q;
    logic             misalign_q, bus_err_q;

    logic             is_mem, aligned, issue, misalign, timeout_hit;
    logic             wb_regwrite_d;
    logic [REG_W-1:0] wb_dest_d;
    logic [31:0]      wb_data_d, wb_pc_d;

    assign is_mem      = ex_memread | ex_memwrite;
    assign aligned     = (ex_alu_result[1:0] == 2'b00);
    assign issue       = (state_q == IDLE) && is_mem && aligned;
    assign misalign    = (state_q == IDLE) && is_mem && !aligned;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        if (state_q == IDLE) mem_stall = issue;
        else                 mem_stall = !dmem.ready && !timeout_hit;
    end

    always_comb begin
        wb_regwrite_d = 1'b0;
        wb_dest_d     = ex_dest;
        wb_data_d     = ex_alu_result;
        wb_pc_d       = BUBBLE_PC;
        if (state_q == IDLE) begin
            if (misalign) begin
                wb_pc_d = ex_pc;
            end else if (!issue) begin
                wb_regwrite_d = ex_regwrite;
                wb_pc_d       = ex_pc;
            end
        end else if (dmem.ready) begin
            wb_regwrite_d = regwrite_q;
            wb_dest_d     = dest_q;
            wb_pc_d       = pc_q;
            wb_data_d     = (wbdata_q && !we_q) ? dmem.rdata : addr_q;
        end else if (timeout_hit) begin
            wb_dest_d = dest_q;
            wb_pc_d   = pc_q;
            wb_data_d = addr_q;
        end
    end

    // Stores are latched with regwrite cleared so they never write back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wbdata_q   <= 1'b0;
            regwrite_q <= 1'b0;
            dest_q     <= '0;
            pc_q       <= BUBBLE_PC;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= misalign;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        req_q      <= 1'b1;
                        we_q       <= ex_memwrite;
                        addr_q     <= word_align(ex_alu_result);
                        wdata_q    <= ex_busb;
                        wbdata_q   <= ex_wbdata;
                        regwrite_q <= ex_regwrite & ~ex_memwrite;
                        dest_q     <= ex_dest;
                        pc_q       <= ex_pc;
                        cnt_q      <= '0;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem.ready) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (timeout_hit) begin
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.wdata   = wdata_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;
    assign dbg_state    = state_q;

    mem_wb_reg u_mem_wb (
        .clk        (clk),
        .reset      (reset),
        .regwrite_i (wb_regwrite_d),
        .dest_i     (wb_dest_d),
        .data_i     (wb_data_d),
        .pc_i       (wb_pc_d),
        .regwrite_o (wb_regwrite),
        .dest_o     (wb_dest),
        .data_o     (wb_data),
        .pc_o       (wb_pc)
    );

endmodule
